// File: rtl/odesa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odesa_pkg
//  Description : Shared constants for the ODESA output-layer scorer:
//                neuron count, default widths and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package odesa_pkg;

    localparam int c_NEURONS         = 4;
    localparam int c_IDX_W           = $clog2(c_NEURONS);
    localparam int c_DEF_CNT_WIDTH   = 8;
    localparam int c_DEF_TALLY_WIDTH = 16;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WINDOW = 2'd1;
    localparam logic [1:0] c_ST_DECIDE = 2'd2;
    localparam logic [1:0] c_ST_REPORT = 2'd3;

endpackage : odesa_pkg
`default_nettype wire

// File: rtl/odesa_scorer_if.sv
`default_nettype none
// ============================================================================
//  Module      : odesa_scorer_if
//  Description : Sample/label/window controls into the scorer and the
//                per-sample and per-epoch results out of it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface odesa_scorer_if
    import odesa_pkg::*;
#(
    parameter int p_tally_width = c_DEF_TALLY_WIDTH
);
    logic [c_NEURONS-1:0]     i_spike;
    logic [c_NEURONS-1:0]     i_label;
    logic                     i_win_start;
    logic                     i_win_end;
    logic                     i_endof_epochs;
    logic [c_NEURONS-1:0]     o_pred;
    logic                     o_result_valid;
    logic                     o_correct;
    logic                     o_busy;
    logic [p_tally_width-1:0] o_total;
    logic [p_tally_width-1:0] o_hits;
    logic                     o_epoch_valid;

    // Driver side (stimulus source / upstream logic)
    modport master (
        output i_spike, i_label, i_win_start, i_win_end, i_endof_epochs,
        input  o_pred, o_result_valid, o_correct, o_busy,
               o_total, o_hits, o_epoch_valid
    );

    // Scorer side
    modport slave (
        input  i_spike, i_label, i_win_start, i_win_end, i_endof_epochs,
        output o_pred, o_result_valid, o_correct, o_busy,
               o_total, o_hits, o_epoch_valid
    );
endinterface : odesa_scorer_if
`default_nettype wire

// File: rtl/odesa_spike_counter.sv
`default_nettype none
// ============================================================================
//  Module      : odesa_spike_counter
//  Description : Per-neuron spike counter with synchronous clear (priority)
//                and increment enable, saturating at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module odesa_spike_counter
    import odesa_pkg::*;
#(
    parameter int p_cnt_width = c_DEF_CNT_WIDTH
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_clr,
    input  wire logic                   i_en,
    output logic      [p_cnt_width-1:0] o_cnt
);

    logic [p_cnt_width-1:0] r_cnt_q;
    logic [p_cnt_width-1:0] w_cnt_d;

    // Clear wins over counting so a restarted window ignores its start-cycle spike
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt_q;

endmodule : odesa_spike_counter
`default_nettype wire

// File: rtl/odesa_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : odesa_scorer
//  Description : Counts output-neuron spikes over a sample window, picks the
//                winning neuron (ties to lowest index), compares it with the
//                one-hot label and keeps per-epoch total/hit tallies.
//  Revision    : 1.0 - initial release
// ============================================================================
module odesa_scorer
    import odesa_pkg::*;
#(
    parameter int p_cnt_width   = c_DEF_CNT_WIDTH,
    parameter int p_tally_width = c_DEF_TALLY_WIDTH
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    odesa_scorer_if.slave bus
);

    logic [1:0]               r_state_q;
    logic [1:0]               w_state_d;
    logic [c_NEURONS-1:0]     r_label_q;
    logic [c_NEURONS-1:0]     r_pred_q;
    logic                     r_correct_q;
    logic [p_tally_width-1:0] r_run_total_q;
    logic [p_tally_width-1:0] r_run_hits_q;
    logic [p_tally_width-1:0] r_total_q;
    logic [p_tally_width-1:0] r_hits_q;
    logic                     r_epoch_valid_q;
    logic                     r_pending_q;

    logic                     w_idle;
    logic                     w_window;
    logic                     w_clr;
    logic                     w_snap;
    logic [p_cnt_width-1:0]   w_cnt [c_NEURONS];
    logic [p_cnt_width-1:0]   w_max;
    logic [c_IDX_W-1:0]       w_idx;
    logic [c_NEURONS-1:0]     w_pred_d;
    logic                     w_correct_d;

    assign w_idle   = (r_state_q == c_ST_IDLE);
    assign w_window = (r_state_q == c_ST_WINDOW);

    // A window opens from IDLE or restarts from WINDOW; both clear the counters
    assign w_clr  = bus.i_win_start && (w_idle || w_window);
    // Epoch snapshot happens only while idle, either on request or deferred
    assign w_snap = w_idle && (bus.i_endof_epochs || r_pending_q);

    generate
        for (genvar n = 0; n < c_NEURONS; n++) begin : g_neuron
            odesa_spike_counter #(
                .p_cnt_width (p_cnt_width)
            ) u_cnt (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_clr (w_clr),
                .i_en  (w_window && bus.i_spike[n]),
                .o_cnt (w_cnt[n])
            );
        end
    endgenerate

    // Winner search: strict greater-than keeps the lowest index on ties
    always_comb begin
        w_max    = w_cnt[0];
        w_idx    = '0;
        w_pred_d = '0;
        for (int i = 1; i < c_NEURONS; i++) begin
            if (w_cnt[i] > w_max) begin
                w_max = w_cnt[i];
                w_idx = c_IDX_W'(i);
            end
        end
        if (w_max != '0) begin
            w_pred_d[w_idx] = 1'b1;
        end
    end

    assign w_correct_d = (w_pred_d != '0) && (w_pred_d == r_label_q);

    // Next-state logic; a restart inside WINDOW takes priority over window end
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (bus.i_win_start) w_state_d = c_ST_WINDOW;
            end
            c_ST_WINDOW: begin
                if (bus.i_win_start)    w_state_d = c_ST_WINDOW;
                else if (bus.i_win_end) w_state_d = c_ST_DECIDE;
            end
            c_ST_DECIDE: w_state_d = c_ST_REPORT;
            default:     w_state_d = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Label capture at window open/restart; prediction registered in DECIDE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_label_q   <= '0;
            r_pred_q    <= '0;
            r_correct_q <= 1'b0;
        end else begin
            if (w_clr) begin
                r_label_q <= bus.i_label;
            end
            if (r_state_q == c_ST_DECIDE) begin
                r_pred_q    <= w_pred_d;
                r_correct_q <= w_correct_d;
            end
        end
    end

    // Running tallies: saturating increment in REPORT, cleared on snapshot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run_total_q <= '0;
            r_run_hits_q  <= '0;
        end else if (w_snap) begin
            r_run_total_q <= '0;
            r_run_hits_q  <= '0;
        end else if (r_state_q == c_ST_REPORT) begin
            if (r_run_total_q != '1) begin
                r_run_total_q <= r_run_total_q + 1'b1;
            end
            if (r_correct_q && (r_run_hits_q != '1)) begin
                r_run_hits_q <= r_run_hits_q + 1'b1;
            end
        end
    end

    // Epoch snapshot, its one-cycle valid pulse and the deferred-request flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_total_q       <= '0;
            r_hits_q        <= '0;
            r_epoch_valid_q <= 1'b0;
            r_pending_q     <= 1'b0;
        end else begin
            r_epoch_valid_q <= w_snap;
            if (w_snap) begin
                r_total_q   <= r_run_total_q;
                r_hits_q    <= r_run_hits_q;
                r_pending_q <= 1'b0;
            end else if (!w_idle && bus.i_endof_epochs) begin
                r_pending_q <= 1'b1;
            end
        end
    end

    assign bus.o_pred         = r_pred_q;
    assign bus.o_correct      = r_correct_q;
    assign bus.o_result_valid = (r_state_q == c_ST_REPORT);
    assign bus.o_busy         = !w_idle;
    assign bus.o_total        = r_total_q;
    assign bus.o_hits         = r_hits_q;
    assign bus.o_epoch_valid  = r_epoch_valid_q;

endmodule : odesa_scorer
`default_nettype wire

// File: tb/tb_odesa_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odesa_scorer
//  Description : Self-checking bench for odesa_scorer: table vectors,
//                directed multi-cycle corner cases and randomized samples
//                checked against a count-and-argmax reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odesa_scorer;
    import odesa_pkg::*;

    localparam int c_CW = 8;
    localparam int c_TW = 16;
    localparam int c_SAT = (1 << c_CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    odesa_scorer_if #(.p_tally_width(c_TW)) bus ();

    odesa_scorer #(
        .p_cnt_width   (c_CW),
        .p_tally_width (c_TW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] label;
        int         c0, c1, c2, c3;
        logic [3:0] pred;
        logic       corr;
    } vec_t;

    vec_t       vecs [8];
    int         checks = 0;
    int         errors = 0;
    int         m_total = 0;
    int         m_hits  = 0;
    logic [3:0] spk_q [$];
    logic [3:0] start_spk = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count each neuron's spikes, saturate, take the first maximum
    function automatic logic [3:0] model_pred();
        int c [4];
        int best;
        int bestval;
        for (int n = 0; n < 4; n++) c[n] = 0;
        foreach (spk_q[i])
            for (int n = 0; n < 4; n++)
                if (spk_q[i][n]) c[n]++;
        best = -1;
        bestval = 0;
        for (int n = 0; n < 4; n++) begin
            if (c[n] > c_SAT) c[n] = c_SAT;
            if (c[n] > bestval) begin
                bestval = c[n];
                best = n;
            end
        end
        return (best < 0) ? 4'b0000 : (4'b0001 << best);
    endfunction

    task automatic fill_from_counts(input int c0, input int c1, input int c2, input int c3);
        int len;
        logic [3:0] v;
        len = 1;
        if (c0 > len) len = c0;
        if (c1 > len) len = c1;
        if (c2 > len) len = c2;
        if (c3 > len) len = c3;
        spk_q.delete();
        for (int i = 0; i < len; i++) begin
            v = {i < c3, i < c2, i < c1, i < c0};
            spk_q.push_back(v);
        end
    endtask

    // Opens a window, plays spk_q (win_end on the last entry), checks the result
    task automatic run_sample(input logic [3:0] label, input logic [3:0] exp_pred,
                              input logic exp_corr, input int eoe_mask, input string tag);
        bus.i_label     = label;
        bus.i_win_start = 1'b1;
        bus.i_spike     = start_spk;
        tick();
        bus.i_win_start = 1'b0;
        for (int i = 0; i < spk_q.size(); i++) begin
            bus.i_spike        = spk_q[i];
            bus.i_win_end      = (i == spk_q.size() - 1);
            bus.i_endof_epochs = (i < 32) ? eoe_mask[i] : 1'b0;
            if (i == 0) begin
                @(negedge clk);
                chk({tag, " busy_window"}, 32'(bus.o_busy), 32'd1);
            end
            tick();
        end
        bus.i_spike        = 4'b0000;
        bus.i_win_end      = 1'b0;
        bus.i_endof_epochs = 1'b0;
        @(negedge clk);
        chk({tag, " valid_early"}, 32'(bus.o_result_valid), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, " valid"},   32'(bus.o_result_valid), 32'd1);
        chk({tag, " pred"},    32'(bus.o_pred),         32'(exp_pred));
        chk({tag, " correct"}, 32'(bus.o_correct),      32'(exp_corr));
        tick();
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(bus.o_result_valid), 32'd0);
        chk({tag, " idle"},       32'(bus.o_busy),         32'd0);
        m_total++;
        if (exp_corr) m_hits++;
    endtask

    // End-of-epoch request issued while idle
    task automatic epoch_flush(input string tag);
        bus.i_endof_epochs = 1'b1;
        tick();
        bus.i_endof_epochs = 1'b0;
        @(negedge clk);
        chk({tag, " epoch_valid"}, 32'(bus.o_epoch_valid), 32'd1);
        chk({tag, " total"},       32'(bus.o_total),       32'(m_total));
        chk({tag, " hits"},        32'(bus.o_hits),        32'(m_hits));
        m_total = 0;
        m_hits  = 0;
        tick();
        @(negedge clk);
        chk({tag, " epoch_drop"}, 32'(bus.o_epoch_valid), 32'd0);
    endtask

    initial begin
        int         len;
        int         nres;
        int         nepo;
        logic [3:0] lbl;
        logic [3:0] ep;
        logic [3:0] rnd;

        vecs[0] = '{4'b0010, 1, 3, 0, 0, 4'b0010, 1'b1};
        vecs[1] = '{4'b1000, 0, 0, 5, 5, 4'b0100, 1'b0};
        vecs[2] = '{4'b0001, 0, 0, 0, 0, 4'b0000, 1'b0};
        vecs[3] = '{4'b0001, 7, 2, 0, 9, 4'b1000, 1'b0};
        vecs[4] = '{4'b1000, 0, 0, 0, 1, 4'b1000, 1'b1};
        vecs[5] = '{4'b0011, 4, 0, 0, 0, 4'b0001, 1'b0};
        vecs[6] = '{4'b0100, 2, 6, 6, 1, 4'b0010, 1'b0};
        vecs[7] = '{4'b0100, 0, 0, 3, 2, 4'b0100, 1'b1};

        bus.i_spike        = 4'b0000;
        bus.i_label        = 4'b0000;
        bus.i_win_start    = 1'b0;
        bus.i_win_end      = 1'b0;
        bus.i_endof_epochs = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy",   32'(bus.o_busy),         32'd0);
        chk("rst pred",   32'(bus.o_pred),         32'd0);
        chk("rst corr",   32'(bus.o_correct),      32'd0);
        chk("rst valid",  32'(bus.o_result_valid), 32'd0);
        chk("rst epoch",  32'(bus.o_epoch_valid),  32'd0);
        chk("rst total",  32'(bus.o_total),        32'd0);
        chk("rst hits",   32'(bus.o_hits),         32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            fill_from_counts(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            run_sample(vecs[i].label, vecs[i].pred, vecs[i].corr, 0, $sformatf("vec%0d", i));
        end
        epoch_flush("table");

        // Restart inside a window: the first sample is discarded
        bus.i_label = 4'b1000;
        bus.i_win_start = 1'b1;
        tick();
        bus.i_win_start = 1'b0;
        bus.i_spike = 4'b1000;
        repeat (4) tick();
        spk_q.delete();
        spk_q.push_back(4'b0001);
        spk_q.push_back(4'b0001);
        start_spk = 4'b1000;
        run_sample(4'b0001, 4'b0001, 1'b1, 0, "restart");
        start_spk = 4'b0000;

        // Saturation
        fill_from_counts(300, 0, 0, 0);
        run_sample(4'b0001, 4'b0001, 1'b1, 0, "sat1");
        chk("sat1 counter", 32'(dut.g_neuron[0].u_cnt.o_cnt), 32'(c_SAT));
        fill_from_counts(256, 290, 0, 0);
        run_sample(4'b0010, 4'b0001, 1'b0, 0, "sat2");
        chk("sat2 counter", 32'(dut.g_neuron[1].u_cnt.o_cnt), 32'(c_SAT));
        epoch_flush("restart_sat");

        // Epoch request during the 4th window (pulsed twice, counts once)
        fill_from_counts(vecs[0].c0, vecs[0].c1, vecs[0].c2, vecs[0].c3);
        run_sample(vecs[0].label, vecs[0].pred, vecs[0].corr, 0, "ep_s1");
        fill_from_counts(vecs[1].c0, vecs[1].c1, vecs[1].c2, vecs[1].c3);
        run_sample(vecs[1].label, vecs[1].pred, vecs[1].corr, 0, "ep_s2");
        fill_from_counts(vecs[4].c0, vecs[4].c1, vecs[4].c2, vecs[4].c3);
        run_sample(vecs[4].label, vecs[4].pred, vecs[4].corr, 0, "ep_s3");
        fill_from_counts(0, 0, 4, 1);
        run_sample(4'b0100, 4'b0100, 1'b1, 32'b1010, "ep_s4");
        chk("pend epoch_early", 32'(bus.o_epoch_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("pend epoch_valid", 32'(bus.o_epoch_valid), 32'd1);
        chk("pend total",       32'(bus.o_total),       32'd4);
        chk("pend hits",        32'(bus.o_hits),        32'd3);
        m_total = 0;
        m_hits  = 0;
        tick();
        @(negedge clk);
        chk("pend single", 32'(bus.o_epoch_valid), 32'd0);
        fill_from_counts(vecs[0].c0, vecs[0].c1, vecs[0].c2, vecs[0].c3);
        run_sample(vecs[0].label, vecs[0].pred, vecs[0].corr, 0, "ep_s5");
        epoch_flush("after_pend");

        // Randomized samples with stray controls between windows
        for (int s = 0; s < 20; s++) begin
            len = $urandom_range(0, 3);
            for (int g = 0; g < len; g++) begin
                rnd = 4'($urandom);
                bus.i_spike   = rnd;
                bus.i_win_end = 1'($urandom);
                tick();
                @(negedge clk);
                chk($sformatf("rnd%0d idle_gap", s), 32'(bus.o_busy), 32'd0);
            end
            bus.i_spike   = 4'b0000;
            bus.i_win_end = 1'b0;
            len = $urandom_range(1, 30);
            spk_q.delete();
            for (int i = 0; i < len; i++) begin
                rnd = 4'($urandom);
                spk_q.push_back(rnd);
            end
            start_spk = 4'($urandom);
            if ($urandom_range(0, 3) == 0) lbl = 4'($urandom);
            else                            lbl = 4'b0001 << $urandom_range(0, 3);
            ep = model_pred();
            run_sample(lbl, ep, (ep != 4'b0000) && (ep == lbl), 0, $sformatf("rnd%0d", s));
        end
        start_spk = 4'b0000;
        epoch_flush("random");

        // Reset in the middle of a window with an epoch request pending
        fill_from_counts(vecs[0].c0, vecs[0].c1, vecs[0].c2, vecs[0].c3);
        run_sample(vecs[0].label, vecs[0].pred, vecs[0].corr, 0, "pre_rst");
        epoch_flush("pre_rst");
        bus.i_label = 4'b0010;
        bus.i_win_start = 1'b1;
        tick();
        bus.i_win_start = 1'b0;
        bus.i_spike = 4'b0010;
        repeat (3) tick();
        bus.i_endof_epochs = 1'b1;
        tick();
        bus.i_endof_epochs = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst busy",    32'(bus.o_busy),         32'd0);
        chk("mid_rst pred",    32'(bus.o_pred),         32'd0);
        chk("mid_rst corr",    32'(bus.o_correct),      32'd0);
        chk("mid_rst valid",   32'(bus.o_result_valid), 32'd0);
        chk("mid_rst epoch",   32'(bus.o_epoch_valid),  32'd0);
        chk("mid_rst total",   32'(bus.o_total),        32'd0);
        chk("mid_rst hits",    32'(bus.o_hits),         32'd0);
        chk("mid_rst counter", 32'(dut.g_neuron[1].u_cnt.o_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.i_win_end = 1'b1;
        tick();
        bus.i_win_end = 1'b0;
        bus.i_spike = 4'b0000;
        nres = 0;
        nepo = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_result_valid) nres++;
            if (bus.o_epoch_valid)  nepo++;
            tick();
        end
        chk("post_rst no_result", 32'(nres), 32'd0);
        chk("post_rst no_epoch",  32'(nepo), 32'd0);
        m_total = 0;
        m_hits  = 0;
        epoch_flush("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_odesa_scorer
`default_nettype wire
